// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int DMEM_DEPTH = 512;
  localparam int DMEM_AW    = 32;
  localparam int DMEM_DW    = 32;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_LOAD = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [DMEM_DW-1:0] wdata;
  } req_t;

  // Full-width range check: no truncation, so huge addresses are rejected.
  function automatic logic addr_in_range(input logic [DMEM_AW-1:0] addr,
                                         input int unsigned depth);
    return addr < DMEM_AW'(depth);
  endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module dmem_rr_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       sel,
  output logic       any
);

  // Combinational pick; sel is don't-care when nothing is valid.
  always_comb begin
    any = |valid;
    sel = 1'b0;
    if (valid == 2'b11) sel = ~last_grant;
    else                sel = valid[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises the core and loader ports onto the single-port data memory.
// One request in flight at a time: IDLE (accept) -> ACCESS -> RESP.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int AW    = DMEM_AW,
  parameter int DW    = DMEM_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [1:0]    req_we,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic [1:0]    rsp_valid,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_rdata
);

  state_t        state_q, state_d;
  logic          last_grant_q;
  logic          port_q;
  logic          err_q;
  req_t          lat_q;
  logic [DW-1:0] rdata_q;

  logic          sel;
  logic          any;
  logic          accept;
  logic          in_range;
  req_t          port_req [2];

  assign port_req[0] = '{we: req_we[0], addr: req_addr0, wdata: req_wdata0};
  assign port_req[1] = '{we: req_we[1], addr: req_addr1, wdata: req_wdata1};

  dmem_rr_pick u_pick (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .sel        (sel),
    .any        (any)
  );

  // In IDLE the picked port is always ready, so any valid means an accept.
  assign accept   = (state_q == IDLE) && any;
  assign in_range = addr_in_range(lat_q.addr, DEPTH);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: fixed three-beat sequence per accepted request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and grant history, loaded on the accept edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_q        <= '0;
      port_q       <= PORT_CORE;
      last_grant_q <= PORT_LOAD;
    end else if (accept) begin
      lat_q        <= port_req[sel];
      port_q       <= sel;
      last_grant_q <= sel;
    end
  end

  // Response capture at the edge closing ACCESS; writes/errors return 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else if (state_q == ACCESS) begin
      err_q   <= ~in_range;
      rdata_q <= (in_range && !lat_q.we) ? mem_rdata : '0;
    end
  end

  // Handshake, memory strobes and response outputs.
  always_comb begin
    req_ready = '0;
    // Gated by reset so ready stays low while reset is asserted.
    if (accept && reset) req_ready[sel] = 1'b1;

    mem_addr  = lat_q.addr;
    mem_wdata = lat_q.wdata;
    mem_read  = (state_q == ACCESS) && in_range && !lat_q.we;
    mem_write = (state_q == ACCESS) && in_range &&  lat_q.we;

    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[port_q] = 1'b1;
    rsp_err   = (state_q == RESP) && err_q;
    rsp_rdata = rdata_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random two-port
// traffic, checked against a transaction-level model of the arbiter.
module tb_dmem_arbiter;

  localparam int DEPTH = 512;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic        rsp_err, mem_write, mem_read;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] tb_mem  [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  int          c = 0;
  int          last_acc = -100;
  logic        m_last = 1'b1;
  logic        m_port, m_we, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        acc_now;
  logic        acc_sel;
  logic [1:0]  obs_ready, obs_rsp;
  logic        obs_err;
  logic [31:0] obs_rdata;

  always #5 clock = ~clock;

  assign mem_rdata = (mem_addr < DEPTH) ? tb_mem[mem_addr[8:0]] : 32'hBAD0_BAD0;

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, c);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {req_ready, rsp_valid, rsp_err, mem_write, mem_read}, '0);
    chk({tag, "_rdata"}, rsp_rdata, '0);
    chk({tag, "_maddr"}, mem_addr, '0);
    chk({tag, "_mwdata"}, mem_wdata, '0);
  endtask

  task automatic set_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    if (p == 0) begin req_addr0 = a; req_wdata0 = d; end
    else        begin req_addr1 = a; req_wdata1 = d; end
  endtask

  task automatic rand_req(input int p);
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = 32'd512 + $urandom_range(0, 3);
      1:       a = 32'd511;
      2:       a = 32'hFFFF_FFFF;
      3:       a = 32'h8000_0000 | $urandom_range(0, 15);
      4:       a = $urandom_range(0, DEPTH - 1);
      default: a = $urandom_range(0, 15);
    endcase
    set_req(p, 1'($urandom_range(0, 1)), a, $urandom);
  endtask

  // One clock: check outputs at the falling edge against the model, model the
  // memory write, predict the grant, then step past the rising edge.
  task automatic tick();
    logic [1:0] exp_ready;
    logic       sel;
    @(negedge clock);
    obs_ready = req_ready;
    obs_rsp   = rsp_valid;
    obs_err   = rsp_err;
    obs_rdata = rsp_rdata;
    exp_ready = 2'b00;
    sel       = 1'b0;
    acc_now   = 1'b0;
    if ((c - last_acc) >= 3 && req_valid != 2'b00) begin
      if (req_valid == 2'b11) sel = ~m_last;
      else                    sel = req_valid[1];
      exp_ready = sel ? 2'b10 : 2'b01;
    end
    chk("req_ready", req_ready, exp_ready);

    if (c == last_acc + 1) begin
      chk("mem_read", mem_read, !m_err && !m_we);
      chk("mem_write", mem_write, !m_err && m_we);
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
    end else begin
      chk("strobes_idle", {mem_write, mem_read}, 2'b00);
    end

    if (c == last_acc + 2) begin
      chk("rsp_valid", rsp_valid, m_port ? 2'b10 : 2'b01);
      chk("rsp_err", rsp_err, m_err);
      chk("rsp_rdata", rsp_rdata, m_rdata);
    end else begin
      chk("rsp_idle", {rsp_valid, rsp_err}, 3'b000);
    end

    if (mem_write && mem_addr < DEPTH) tb_mem[mem_addr[8:0]] = mem_wdata;

    if (exp_ready != 2'b00) begin
      acc_now  = 1'b1;
      acc_sel  = sel;
      last_acc = c;
      m_last   = sel;
      m_port   = sel;
      m_we     = req_we[sel];
      m_addr   = sel ? req_addr1 : req_addr0;
      m_wdata  = sel ? req_wdata1 : req_wdata0;
      m_err    = !(m_addr < DEPTH);
      m_rdata  = 32'h0;
      if (!m_err) begin
        if (m_we) ref_mem[m_addr[8:0]] = m_wdata;
        else      m_rdata = ref_mem[m_addr[8:0]];
      end
    end
    @(posedge clock);
    #1;
    c++;
  endtask

  initial begin
    logic [31:0] m0, m511, v;
    int          glog [4];
    int          ng, diff;

    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      tb_mem[i]  = v;
      ref_mem[i] = v;
    end
    tb_mem[5]  = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;

    // reset with both ports requesting: nothing may be acknowledged
    reset = 1'b0;
    req_valid = 2'b11; req_we = 2'b00;
    req_addr0 = 32'd1; req_addr1 = 32'd2;
    req_wdata0 = '0;   req_wdata1 = '0;
    #22;
    chk_all_zero("reset");
    req_valid = 2'b00;
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // contention from reset: expected order 0,1,0,1
    set_req(0, 1'b0, 32'd1, 32'd0);
    set_req(1, 1'b0, 32'd2, 32'd0);
    ng = 0;
    for (int k = 0; k < 20 && ng < 4; k++) begin
      tick();
      if (obs_ready != 2'b00) begin
        glog[ng] = obs_ready[1] ? 1 : 0;
        ng++;
      end
    end
    chk("contend_count", ng, 4);
    chk("contend_g0", glog[0], 0);
    chk("contend_g1", glog[1], 1);
    chk("contend_g2", glog[2], 0);
    chk("contend_g3", glog[3], 1);
    req_valid = 2'b00;
    repeat (3) tick();

    // single read of addr 5
    set_req(0, 1'b0, 32'd5, 32'd0);
    tick();
    chk("rd_ready", obs_ready, 2'b01);
    req_valid[0] = 1'b0;
    tick();
    tick();
    chk("rd_rsp", obs_rsp, 2'b01);
    chk("rd_data", obs_rdata, 32'hDEADBEEF);
    tick();

    // loader writes then reads back addr 10
    set_req(1, 1'b1, 32'd10, 32'h12345678);
    tick();
    req_valid[1] = 1'b0;
    tick();
    tick();
    chk("wr_rsp", obs_rsp, 2'b10);
    chk("wr_rdata", obs_rdata, 32'h0);
    set_req(1, 1'b0, 32'd10, 32'd0);
    tick();
    req_valid[1] = 1'b0;
    tick();
    tick();
    chk("rb_data", obs_rdata, 32'h12345678);

    // out-of-range write at DEPTH
    m0   = tb_mem[0];
    m511 = tb_mem[511];
    set_req(0, 1'b1, 32'd512, 32'hCAFEF00D);
    tick();
    req_valid[0] = 1'b0;
    tick();
    tick();
    chk("oor_rsp", obs_rsp, 2'b01);
    chk("oor_err", obs_err, 1'b1);
    chk("oor_mem0", tb_mem[0], m0);
    chk("oor_mem511", tb_mem[511], m511);

    // loader request held while the core is in service
    set_req(0, 1'b0, 32'd7, 32'd0);
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 1'b0, 32'd8, 32'd0);
    tick();
    chk("held_access", obs_ready, 2'b00);
    tick();
    chk("held_resp", obs_ready, 2'b00);
    tick();
    chk("held_grant", obs_ready, 2'b10);
    req_valid[1] = 1'b0;
    repeat (3) tick();

    // reset asserted during the ACCESS cycle of a read
    set_req(0, 1'b0, 32'd3, 32'd0);
    tick();
    req_valid = 2'b00;
    reset = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clock);
    reset    = 1'b1;
    last_acc = -100;
    m_last   = 1'b1;
    @(posedge clock);
    #1;
    c++;
    tick();
    chk("rst_norsp0", obs_rsp, 2'b00);
    tick();
    chk("rst_norsp1", obs_rsp, 2'b00);
    set_req(0, 1'b0, 32'd4, 32'd0);
    set_req(1, 1'b0, 32'd6, 32'd0);
    tick();
    chk("rst_tie", obs_ready, 2'b01);
    req_valid[0] = 1'b0;

    // random traffic; the loader request above stays pending into this phase
    for (int k = 0; k < 800; k++) begin
      tick();
      for (int p = 0; p < 2; p++) begin
        if (acc_now && acc_sel == 1'(p)) begin
          if ($urandom_range(0, 1) == 1) rand_req(p);
          else req_valid[p] = 1'b0;
        end else if (!req_valid[p] && $urandom_range(0, 2) == 0) begin
          rand_req(p);
        end
      end
    end
    req_valid = 2'b00;
    repeat (4) tick();

    diff = 0;
    for (int i = 0; i < DEPTH; i++)
      if (tb_mem[i] !== ref_mem[i]) diff++;
    chk("mem_image", diff, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
